// File: rtl/fir_pkg.sv
// Shared helpers for the parametrised FIR filter: width derivation and
// output saturation.
package fir_pkg;

  // Widest sum the saturation helper accepts.
  localparam int SAT_W = 64;

  typedef struct packed {
    logic             sat;
    logic [SAT_W-1:0] val;
  } sat_t;

  function automatic int fir_clog2(input int n);
    int r;
    r = 0;
    for (int v = n - 1; v > 0; v = v >> 1) begin
      r++;
    end
    return r;
  endfunction

  function automatic int fir_sum_w(input int dw, input int cw, input int taps);
    return dw + cw + fir_clog2(taps);
  endfunction

  // Clamp an unsigned sum to ow bits; val is already clamped when sat is set.
  function automatic sat_t fir_saturate(input logic [SAT_W-1:0] sum, input int ow);
    sat_t             r;
    logic [SAT_W-1:0] lim;
    lim   = (SAT_W'(1) << ow) - SAT_W'(1);
    r.sat = (sum > lim);
    r.val = r.sat ? lim : sum;
    return r;
  endfunction

endpackage

// File: rtl/fir_adder_tree.sv
// Combinational pairwise adder tree: sums TAPS unsigned products into SW bits.
module fir_adder_tree
  import fir_pkg::*;
#(
  parameter int PW   = 11,
  parameter int TAPS = 4,
  parameter int SW   = 13
) (
  input  logic [TAPS-1:0][PW-1:0] prods,
  output logic [SW-1:0]           sum
);

  localparam int LVL = fir_clog2(TAPS);
  localparam int N   = 1 << LVL;

  // Heap layout: node 0 is the root, leaves live at N-1 .. 2N-2.
  logic [SW-1:0] node [2*N-1];

  always_comb begin
    for (int i = 0; i < 2 * N - 1; i++) begin
      node[i] = '0;
    end
    for (int i = 0; i < TAPS; i++) begin
      node[N-1+i] = SW'(prods[i]);
    end
    for (int i = N - 2; i >= 0; i--) begin
      node[i] = node[2*i+1] + node[2*i+2];
    end
    sum = node[0];
  end

endmodule

// File: rtl/fir_filter_param.sv
// Streaming unsigned FIR filter: valid-qualified delay line, run-time coefficient
// bank, registered products, registered saturating sum (3-cycle latency).
module fir_filter_param
  import fir_pkg::*;
#(
  parameter int DW   = 8,
  parameter int CW   = 3,
  parameter int TAPS = 4,
  parameter int OW   = 8
) (
  input  logic                       clk,
  input  logic                       srst_n,
  input  logic                       clear,
  input  logic                       in_valid,
  input  logic [DW-1:0]              din,
  input  logic                       coef_we,
  input  logic [fir_clog2(TAPS)-1:0] coef_addr,
  input  logic [CW-1:0]              coef_din,
  output logic                       out_valid,
  output logic [OW-1:0]              dout,
  output logic                       out_sat
);

  localparam int AW = fir_clog2(TAPS);
  localparam int PW = DW + CW;
  localparam int SW = fir_sum_w(DW, CW, TAPS);

  logic [DW-1:0]            tap_reg  [TAPS];
  logic [CW-1:0]            coef_reg [TAPS];
  logic [CW-1:0]            coef_eff [TAPS];
  logic [TAPS-1:0][PW-1:0]  prod_reg;

  logic                     v0_reg;
  logic                     v1_reg;
  logic                     out_valid_reg;
  logic [OW-1:0]            dout_reg;
  logic                     out_sat_reg;

  logic [SW-1:0]            sum;
  sat_t                     sat_res;
  logic [OW-1:0]            dout_next;
  logic                     out_sat_next;

  generate
    for (genvar gi = 0; gi < TAPS; gi++) begin : g_tap
      logic coef_hit;

      // Addresses >= TAPS match no tap and are dropped.
      assign coef_hit = coef_we && (coef_addr == AW'(gi));

      // A write in the product cycle is forwarded so it reaches the sample in flight.
      assign coef_eff[gi] = coef_hit ? coef_din : coef_reg[gi];

      always_ff @(posedge clk) begin
        if (!srst_n) begin
          coef_reg[gi] <= '0;
        end else if (coef_hit) begin
          coef_reg[gi] <= coef_din;
        end
      end

      if (gi == 0) begin : g_head
        always_ff @(posedge clk) begin
          if (!srst_n || clear) begin
            tap_reg[0] <= '0;
          end else if (in_valid) begin
            tap_reg[0] <= din;
          end
        end
      end else begin : g_body
        always_ff @(posedge clk) begin
          if (!srst_n || clear) begin
            tap_reg[gi] <= '0;
          end else if (in_valid) begin
            tap_reg[gi] <= tap_reg[gi-1];
          end
        end
      end

      always_ff @(posedge clk) begin
        if (!srst_n || clear) begin
          prod_reg[gi] <= '0;
        end else begin
          prod_reg[gi] <= PW'(tap_reg[gi]) * PW'(coef_eff[gi]);
        end
      end
    end
  endgenerate

  fir_adder_tree #(
    .PW   (PW),
    .TAPS (TAPS),
    .SW   (SW)
  ) u_tree (
    .prods (prod_reg),
    .sum   (sum)
  );

  assign sat_res   = fir_saturate(SAT_W'(sum), OW);
  assign dout_next = sat_res.val[OW-1:0];
  // The clamped value never spills past OW bits, so the OR only restates the flag.
  assign out_sat_next = sat_res.sat | (|sat_res.val[SAT_W-1:OW]);

  always_ff @(posedge clk) begin
    if (!srst_n) begin
      v0_reg        <= 1'b0;
      v1_reg        <= 1'b0;
      out_valid_reg <= 1'b0;
      dout_reg      <= '0;
      out_sat_reg   <= 1'b0;
    end else if (clear) begin
      v0_reg        <= 1'b0;
      v1_reg        <= 1'b0;
      out_valid_reg <= 1'b0;
    end else begin
      v0_reg        <= in_valid;
      v1_reg        <= v0_reg;
      out_valid_reg <= v1_reg;
      if (v1_reg) begin
        dout_reg    <= dout_next;
        out_sat_reg <= out_sat_next;
      end
    end
  end

  assign out_valid = out_valid_reg;
  assign dout      = dout_reg;
  assign out_sat   = out_sat_reg;

endmodule
